// File: rtl/alu_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv
//  Description : Iterative multiply/divide unit (MULT, MULTU, DIV, DIVU).
//                Works on operand magnitudes and retires one bit per clock
//                into a double-width accumulator. A FIXUP cycle then applies
//                the result signs and writes the architectural HI/LO
//                registers. MTHI/MTLO write ports are also provided.
//
//  Ports       : CLK    - clock, rising edge
//                nRST   - asynchronous active-low reset
//                start  - operation request, accepted only while idle
//                op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//                porta  - multiplicand / dividend
//                portb  - multiplier / divisor
//                flush  - abort the in-flight operation
//                wr_hi  - MTHI strobe
//                wr_lo  - MTLO strobe
//                wdat   - MTHI/MTLO data
//                busy   - operation in flight (registered)
//                done   - one-cycle pulse when hi/lo take a result
//                dz     - last completed operation divided by zero (sticky)
//                hi     - HI register (product upper half / remainder)
//                lo     - LO register (product lower half / quotient)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WORD_W-1:0] porta,
    input  logic [WORD_W-1:0] portb,
    input  logic              flush,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic [WORD_W-1:0] wdat,
    output logic              busy,
    output logic              done,
    output logic              dz,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [CNT_W-1:0]      r_cnt;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WORD_W-1:0]     r_opnd;
    // Multiply: {partial product high, multiplier/product low}.
    // Divide:   {partial remainder, dividend/quotient}.
    logic [2*WORD_W-1:0]   r_acc;
    logic                  r_is_div;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_div0;
    logic [WORD_W-1:0]     r_dividend;

    logic                  r_busy;
    logic                  r_done;
    logic                  r_dz;
    logic [WORD_W-1:0]     r_hi;
    logic [WORD_W-1:0]     r_lo;

    logic                  w_accept;
    logic                  w_signed;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [WORD_W-1:0]     w_a_mag;
    logic [WORD_W-1:0]     w_b_mag;

    logic [WORD_W:0]       w_mul_sum;
    logic [2*WORD_W-1:0]   w_mul_nxt;
    logic [WORD_W:0]       w_rem_sh;
    logic [WORD_W-1:0]     w_div_diff;
    logic                  w_div_ge;
    logic [2*WORD_W-1:0]   w_div_nxt;

    logic [2*WORD_W-1:0]   w_prod_fix;
    logic [WORD_W-1:0]     w_quo_fix;
    logic [WORD_W-1:0]     w_rem_fix;

    // ------------------------------------------------------------------
    // Operand conditioning at accept time
    // ------------------------------------------------------------------
    assign w_accept = (r_state == S_IDLE) && start && !flush;
    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & porta[WORD_W-1];
    assign w_b_neg  = w_signed & portb[WORD_W-1];
    // -2^(WORD_W-1) maps to 2^(WORD_W-1), which still fits as unsigned.
    assign w_a_mag  = w_a_neg ? -porta : porta;
    assign w_b_mag  = w_b_neg ? -portb : portb;

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply: add the multiplicand when the
    // current multiplier bit is set, then shift the whole accumulator
    // right, keeping the carry in the top bit.
    // ------------------------------------------------------------------
    assign w_mul_sum = {1'b0, r_acc[2*WORD_W-1:WORD_W]}
                     + (r_acc[0] ? {1'b0, r_opnd} : {(WORD_W+1){1'b0}});
    assign w_mul_nxt = {w_mul_sum, r_acc[WORD_W-1:1]};

    // ------------------------------------------------------------------
    // One iteration of restoring division: shift the next dividend bit
    // into the remainder, subtract the divisor when it fits, and shift
    // the resulting quotient bit into the low end.
    // ------------------------------------------------------------------
    assign w_rem_sh   = {r_acc[2*WORD_W-1:WORD_W], r_acc[WORD_W-1]};
    assign w_div_ge   = (w_rem_sh >= {1'b0, r_opnd});
    assign w_div_diff = w_rem_sh[WORD_W-1:0] - r_opnd;
    assign w_div_nxt  = {(w_div_ge ? w_div_diff : w_rem_sh[WORD_W-1:0]),
                         r_acc[WORD_W-2:0], w_div_ge};

    // ------------------------------------------------------------------
    // Sign fix-up of the finished magnitudes
    // ------------------------------------------------------------------
    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_q ? -r_acc[WORD_W-1:0] : r_acc[WORD_W-1:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[2*WORD_W-1:WORD_W]
                                : r_acc[2*WORD_W-1:WORD_W];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == c_last_cnt) w_state_nxt = S_FIXUP;
            S_FIXUP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // A squash overrides everything, including a concurrent start.
        if (flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (r_state == S_FIXUP) && !flush;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt      <= '0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_dividend <= '0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_is_div   <= op[1];
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_div0     <= op[1] && (portb == '0);
            r_dividend <= porta;
            r_opnd     <= op[1] ? w_b_mag : w_a_mag;
            r_acc      <= {{WORD_W{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
        end else if ((r_state == S_CALC) && !flush) begin
            r_cnt      <= r_cnt + CNT_W'(1);
            r_acc      <= r_is_div ? w_div_nxt : w_mul_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Architectural HI/LO/dz
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hi <= '0;
            r_lo <= '0;
            r_dz <= 1'b0;
        end else if (w_accept) begin
            r_dz <= 1'b0;
        end else if ((r_state == S_FIXUP) && !flush) begin
            r_dz <= r_div0;
            if (!r_is_div) begin
                r_hi <= w_prod_fix[2*WORD_W-1:WORD_W];
                r_lo <= w_prod_fix[WORD_W-1:0];
            end else if (r_div0) begin
                r_hi <= r_dividend;
                r_lo <= '1;
            end else begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end
        end else if (!r_busy && !start) begin
            // MTHI/MTLO only land while idle with no competing request.
            if (wr_hi) r_hi <= wdat;
            if (wr_lo) r_lo <= wdat;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dz   = r_dz;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv
//  Description : Self-checking bench for alu_muldiv. Directed corner cases
//                plus randomized operations compared against a plain
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;

    localparam int W = 32;

    logic          CLK   = 1'b0;
    logic          nRST  = 1'b0;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic          wr_hi = 1'b0;
    logic          wr_lo = 1'b0;
    logic [1:0]    op    = 2'd0;
    logic [W-1:0]  porta = '0;
    logic [W-1:0]  portb = '0;
    logic [W-1:0]  wdat  = '0;
    logic          busy;
    logic          done;
    logic          dz;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int            n_tests = 0;
    int            n_fail  = 0;

    // Expected architectural state
    logic [W-1:0]  m_hi = '0;
    logic [W-1:0]  m_lo = '0;
    logic          m_dz = 1'b0;

    alu_muldiv #(.WORD_W(W)) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .start (start),
        .op    (op),
        .porta (porta),
        .portb (portb),
        .flush (flush),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdat  (wdat),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] h,
                                   output logic [W-1:0] l, output logic z);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z  = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            2'd0: begin
                p = sa * sb;
                h = p[63:32];
                l = p[31:0];
            end
            2'd1: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32];
                l = p[31:0];
            end
            default: begin
                if (b == '0) begin
                    h = a;
                    l = '1;
                    z = 1'b1;
                end else if (o == 2'd2) begin
                    p = sa / sb;
                    l = p[31:0];
                    p = sa % sb;
                    h = p[31:0];
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 15));
            4:       return -W'($urandom_range(1, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // Issue one operation at a negedge and follow it to completion.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input string tag,
                         input bit with_wr_lo);
        int n;
        int nb;
        @(negedge CLK);
        op    = o;
        porta = a;
        portb = b;
        start = 1'b1;
        wr_lo = with_wr_lo;
        wdat  = 32'hDEAD_BEEF;
        @(posedge CLK);
        #1;
        start = 1'b0;
        wr_lo = 1'b0;
        chk({tag, "_busy_e0"}, busy, 1'b1);
        chk({tag, "_done_e0"}, done, 1'b0);
        chk({tag, "_dz_clr"}, dz, 1'b0);
        if (with_wr_lo) chk({tag, "_wrlo_drop"}, lo, m_lo);
        ref_op(o, a, b, m_hi, m_lo, m_dz);
        n  = 0;
        nb = 1;
        while (!done && n < 60) begin
            @(posedge CLK);
            #1;
            n++;
            if (busy) nb++;
        end
        chk({tag, "_latency"}, n, W + 1);
        chk({tag, "_busy_cyc"}, nb, W + 1);
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
        chk({tag, "_dz"}, dz, m_dz);
    endtask

    initial begin
        int nd;
        int nbusy;

        // ---------------- reset ----------------
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dz",   dz,   1'b0);
        chk("rst_hi",   hi,   '0);
        chk("rst_lo",   lo,   '0);
        @(negedge CLK);
        nRST = 1'b1;

        // ---------------- directed ----------------
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0);
        chk("multu_max_hi_const", hi, 32'hFFFF_FFFE);
        chk("multu_max_lo_const", lo, 32'h0000_0001);
        do_op(2'd0, -32'd3, 32'd7, "mult_m3x7", 1'b0);
        chk("mult_m3x7_lo_const", lo, 32'hFFFF_FFEB);
        do_op(2'd2, -32'd7, 32'd2, "div_m7d2", 1'b0);
        chk("div_m7d2_lo_const", lo, 32'hFFFF_FFFD);
        chk("div_m7d2_hi_const", hi, 32'hFFFF_FFFF);
        do_op(2'd3, 32'd7, 32'd2, "divu_7d2", 1'b0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
        chk("div_ovf_lo_const", lo, 32'h8000_0000);
        do_op(2'd3, 32'd5, 32'd0, "divu_dz", 1'b0);
        chk("divu_dz_flag", dz, 1'b1);
        do_op(2'd1, 32'd2, 32'd3, "wrlo_w_start", 1'b1);

        // ---------------- MTHI / MTLO ----------------
        @(negedge CLK);
        wr_hi = 1'b1;
        wdat  = 32'h1234_5678;
        @(posedge CLK);
        #1;
        wr_hi = 1'b0;
        m_hi  = 32'h1234_5678;
        chk("mthi_hi", hi, m_hi);
        chk("mthi_lo_keep", lo, m_lo);
        @(negedge CLK);
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdat  = 32'hCAFE_0001;
        @(posedge CLK);
        #1;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        m_hi  = 32'hCAFE_0001;
        m_lo  = 32'hCAFE_0001;
        chk("mthilo_hi", hi, m_hi);
        chk("mthilo_lo", lo, m_lo);

        // ---------------- flush at cycle 10 of a MULT ----------------
        @(negedge CLK);
        op    = 2'd0;
        porta = 32'd1000;
        portb = -32'd9;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        flush = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        nd = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (done) nd++;
        end
        chk("flush_nodone", nd, 0);
        chk("flush_hi", hi, m_hi);
        chk("flush_lo", lo, m_lo);

        // ---------------- flush together with start ----------------
        @(negedge CLK);
        op    = 2'd1;
        porta = 32'd3;
        portb = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", busy, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        chk("flush_start_busy2", busy, 1'b0);

        // ---------------- start and MTHI while busy are ignored ----------------
        @(negedge CLK);
        op    = 2'd3;
        porta = 32'd100;
        portb = 32'd7;
        start = 1'b1;
        @(posedge CLK);
        #1;
        ref_op(2'd3, 32'd100, 32'd7, m_hi, m_lo, m_dz);
        op    = 2'd1;
        porta = 32'd3;
        portb = 32'd3;
        wr_hi = 1'b1;
        wdat  = 32'h5555_AAAA;
        repeat (10) @(posedge CLK);
        #1;
        start = 1'b0;
        wr_hi = 1'b0;
        chk("busy_wrhi_drop", hi, 32'hCAFE_0001);
        nd = 0;
        while (!done && nd < 60) begin
            @(posedge CLK);
            #1;
            nd++;
        end
        chk("held_start_done", done, 1'b1);
        chk("held_start_hi", hi, m_hi);
        chk("held_start_lo", lo, m_lo);
        nbusy = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (busy) nbusy++;
        end
        chk("held_start_not_run", nbusy, 0);

        // ---------------- randomized ----------------
        for (int i = 0; i < 150; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = pick_operand();
            rb = pick_operand();
            do_op(ro, ra, rb, $sformatf("rnd%0d_op%0d", i, ro), 1'b0);
        end

        // ---------------- reset mid-DIV ----------------
        do_op(2'd3, 32'd5, 32'd0, "pre_rst_dz", 1'b0);
        @(negedge CLK);
        op    = 2'd2;
        porta = -32'd12345;
        portb = 32'd17;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (5) @(posedge CLK);
        #3;
        nRST = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_dz",   dz,   1'b0);
        chk("arst_hi",   hi,   '0);
        chk("arst_lo",   lo,   '0);
        @(negedge CLK);
        nRST = 1'b1;
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        do_op(2'd0, 32'h8000_0000, 32'h8000_0000, "post_rst_mult", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
